// File: rtl/ahb_lite_pkg.sv
//==============================================================================
// Module      : ahb_lite_pkg
// Description : Shared AHB-Lite transfer, response and arbiter state encodings.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ahb_lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        OWNED  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ahb_rr_picker.sv
//==============================================================================
// Module      : ahb_rr_picker
// Description : Combinational round-robin picker; searches last+1 .. last.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ahb_rr_picker #(
    parameter int NUM_MASTERS = 4,
    localparam int MW = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          last,
    output logic                   valid,
    output logic [MW-1:0]          idx
);

    logic [MW-1:0] w_cand;

    // Scan from the farthest candidate inwards so the nearest requester wins.
    always_comb begin
        valid  = 1'b0;
        idx    = last;
        w_cand = last;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_cand = MW'((int'(last) + k) % NUM_MASTERS);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ahb_lite_arbiter.sv
//==============================================================================
// Module      : ahb_lite_arbiter
// Description : N-master to 1-slave AHB-Lite arbiter with overlapped data phase.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ahb_lite_arbiter
    import ahb_lite_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW = $clog2(NUM_MASTERS)
) (
    input  logic                             hclk,
    input  logic                             hreset,
    input  logic [NUM_MASTERS-1:0]           m_hbusreq,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr,
    input  logic [NUM_MASTERS-1:0]           m_hmasterlock,
    input  logic [NUM_MASTERS*4-1:0]         m_hprot,
    input  logic [NUM_MASTERS*3-1:0]         m_hsize,
    input  logic [NUM_MASTERS*2-1:0]         m_htrans,
    input  logic [NUM_MASTERS-1:0]           m_hwrite,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata,
    output logic [NUM_MASTERS-1:0]           m_hgrant,
    output logic [DATA_WIDTH-1:0]            m_hrdata,
    output logic                             m_hreadyout,
    output logic [NUM_MASTERS-1:0]           m_hresp,
    output logic [ADDR_WIDTH-1:0]            s_haddr,
    output logic                             s_hmasterlock,
    output logic [3:0]                       s_hprot,
    output logic [2:0]                       s_hsize,
    output logic [1:0]                       s_htrans,
    output logic                             s_hwrite,
    output logic [DATA_WIDTH-1:0]            s_hwdata,
    input  logic [DATA_WIDTH-1:0]            s_hrdata,
    input  logic                             s_hreadyout,
    input  logic                             s_hresp,
    output logic [MW-1:0]                    hmaster
);

    localparam logic [1:0]    C_ST_PARK   = PARK;
    localparam logic [1:0]    C_ST_OWNED  = OWNED;
    localparam logic [1:0]    C_ST_LOCKED = LOCKED;
    localparam logic [1:0]    C_IDLE      = IDLE;
    localparam logic [MW-1:0] C_DEFAULT   = MW'(DEFAULT_MASTER);

    logic [MW-1:0] r_addr_own;
    logic [MW-1:0] r_data_own;
    logic [1:0]    r_state;

    logic [MW-1:0] w_addr_own_nxt;
    logic [1:0]    w_state_nxt;
    logic          w_pick_valid;
    logic [MW-1:0] w_pick_idx;
    logic          w_hop;
    logic [1:0]    w_own_trans;
    logic          w_own_lock;
    logic          w_own_req;

    logic [ADDR_WIDTH-1:0] w_haddr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] w_hwdata [NUM_MASTERS];
    logic [3:0]            w_hprot  [NUM_MASTERS];
    logic [2:0]            w_hsize  [NUM_MASTERS];
    logic [1:0]            w_htrans [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
        assign w_haddr[gi]  = m_haddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_hwdata[gi] = m_hwdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_hprot[gi]  = m_hprot[gi*4 +: 4];
        assign w_hsize[gi]  = m_hsize[gi*3 +: 3];
        assign w_htrans[gi] = m_htrans[gi*2 +: 2];
        assign m_hgrant[gi] = (r_addr_own == MW'(gi));
        assign m_hresp[gi]  = s_hresp & (r_data_own == MW'(gi));
    end

    assign w_own_trans = w_htrans[r_addr_own];
    assign w_own_lock  = m_hmasterlock[r_addr_own];
    assign w_own_req   = m_hbusreq[r_addr_own];

    // A mid-burst owner (BUSY/SEQ) only yields if it has dropped its request.
    assign w_hop = s_hreadyout & ~w_own_lock &
                   ((w_own_trans == C_IDLE) | ~w_own_req);

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req   (m_hbusreq),
        .last  (r_addr_own),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_comb begin
        w_addr_own_nxt = r_addr_own;
        w_state_nxt    = r_state;
        if (w_hop) begin
            if (w_pick_valid) begin
                w_addr_own_nxt = w_pick_idx;
                w_state_nxt    = C_ST_OWNED;
            end else begin
                w_addr_own_nxt = C_DEFAULT;
                w_state_nxt    = C_ST_PARK;
            end
        end else if (s_hreadyout && w_own_lock) begin
            w_state_nxt = C_ST_LOCKED;
        end else if (s_hreadyout && (r_state == C_ST_LOCKED)) begin
            w_state_nxt = C_ST_OWNED;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_addr_own <= C_DEFAULT;
            r_data_own <= C_DEFAULT;
            r_state    <= C_ST_PARK;
        end else begin
            r_addr_own <= w_addr_own_nxt;
            r_state    <= w_state_nxt;
            if (s_hreadyout) begin
                r_data_own <= r_addr_own;
            end
        end
    end

    assign s_haddr       = w_haddr[r_addr_own];
    assign s_hmasterlock = w_own_lock;
    assign s_hprot       = w_hprot[r_addr_own];
    assign s_hsize       = w_hsize[r_addr_own];
    assign s_hwrite      = m_hwrite[r_addr_own];
    assign s_htrans      = hreset ? C_IDLE : w_own_trans;
    assign s_hwdata      = w_hwdata[r_data_own];
    assign m_hrdata      = s_hrdata;
    assign m_hreadyout   = s_hreadyout;
    assign hmaster       = r_addr_own;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_arbiter.sv
//==============================================================================
// Module      : tb_ahb_lite_arbiter
// Description : Directed scoreboard bench for the 4-master AHB-Lite arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ahb_lite_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [5:0] M_G = 6'b000011;
    localparam logic [5:0] M_T = 6'b000100;
    localparam logic [5:0] M_A = 6'b001000;
    localparam logic [5:0] M_W = 6'b010000;
    localparam logic [5:0] M_R = 6'b100000;

    logic            hclk = 1'b0;
    logic            hreset;
    logic [N-1:0]    m_hbusreq;
    logic [N*AW-1:0] m_haddr;
    logic [N-1:0]    m_hmasterlock;
    logic [N*4-1:0]  m_hprot;
    logic [N*3-1:0]  m_hsize;
    logic [N*2-1:0]  m_htrans;
    logic [N-1:0]    m_hwrite;
    logic [N*DW-1:0] m_hwdata;
    logic [N-1:0]    m_hgrant;
    logic [DW-1:0]   m_hrdata;
    logic            m_hreadyout;
    logic [N-1:0]    m_hresp;
    logic [AW-1:0]   s_haddr;
    logic            s_hmasterlock;
    logic [3:0]      s_hprot;
    logic [2:0]      s_hsize;
    logic [1:0]      s_htrans;
    logic            s_hwrite;
    logic [DW-1:0]   s_hwdata;
    logic [DW-1:0]   s_hrdata;
    logic            s_hreadyout;
    logic            s_hresp;
    logic [1:0]      hmaster;

    ahb_lite_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .DEFAULT_MASTER (0)
    ) dut (
        .hclk          (hclk),
        .hreset        (hreset),
        .m_hbusreq     (m_hbusreq),
        .m_haddr       (m_haddr),
        .m_hmasterlock (m_hmasterlock),
        .m_hprot       (m_hprot),
        .m_hsize       (m_hsize),
        .m_htrans      (m_htrans),
        .m_hwrite      (m_hwrite),
        .m_hwdata      (m_hwdata),
        .m_hgrant      (m_hgrant),
        .m_hrdata      (m_hrdata),
        .m_hreadyout   (m_hreadyout),
        .m_hresp       (m_hresp),
        .s_haddr       (s_haddr),
        .s_hmasterlock (s_hmasterlock),
        .s_hprot       (s_hprot),
        .s_hsize       (s_hsize),
        .s_htrans      (s_htrans),
        .s_hwrite      (s_hwrite),
        .s_hwdata      (s_hwdata),
        .s_hrdata      (s_hrdata),
        .s_hreadyout   (s_hreadyout),
        .s_hresp       (s_hresp),
        .hmaster       (hmaster)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        string       name;
        logic [5:0]  mask;
        logic [3:0]  grant;
        logic [1:0]  hm;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: actual=%h expected=%h", nm, fld, act, req);
        end
    endtask

    // Drive one master's address/data signals.
    task automatic drv(input int i, input logic req, input logic [1:0] tr,
                       input logic [31:0] a, input logic lk, input logic wr,
                       input logic [31:0] wd);
        m_hbusreq[2'(i)]     = req;
        m_htrans[i*2 +: 2]   = tr;
        m_haddr[i*AW +: AW]  = a;
        m_hmasterlock[2'(i)] = lk;
        m_hwrite[2'(i)]      = wr;
        m_hwdata[i*DW +: DW] = wd;
    endtask

    // Queue the expected outputs for the current cycle, then advance a cycle.
    task automatic cyc(input string nm, input logic [5:0] mask,
                       input logic [3:0] g, input logic [1:0] hm,
                       input logic [1:0] tr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] rs);
        exp_t e;
        e.name = nm; e.mask = mask; e.grant = g; e.hm = hm;
        e.trans = tr; e.addr = a; e.wdata = wd; e.resp = rs;
        exp_q.push_back(e);
        @(posedge hclk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge hclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.mask[0]) chk(e.name, "m_hgrant", 32'(m_hgrant), 32'(e.grant));
                if (e.mask[1]) chk(e.name, "hmaster",  32'(hmaster),  32'(e.hm));
                if (e.mask[2]) chk(e.name, "s_htrans", 32'(s_htrans), 32'(e.trans));
                if (e.mask[3]) chk(e.name, "s_haddr",  s_haddr,       e.addr);
                if (e.mask[4]) chk(e.name, "s_hwdata", s_hwdata,      e.wdata);
                if (e.mask[5]) chk(e.name, "m_hresp",  32'(m_hresp),  32'(e.resp));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: stimulus did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        hreset      = 1'b1;
        m_hprot     = '0;
        m_hsize     = '0;
        s_hrdata    = 32'hCAFE_0000;
        s_hreadyout = 1'b1;
        s_hresp     = 1'b0;
        for (int i = 0; i < N; i++) drv(i, 1'b0, T_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge hclk);
        #1;

        // Reset state: s_htrans forced IDLE even though master 0 drives NONSEQ
        drv(0, 1'b1, T_NONSEQ, 32'h100, 1'b0, 1'b0, 32'h0);
        cyc("reset", M_G | M_T, 4'b0001, 2'd0, T_IDLE, 0, 0, 0);
        hreset = 1'b0;
        cyc("m0_nodelay", M_G | M_T | M_A, 4'b0001, 2'd0, T_NONSEQ, 32'h100, 0, 0);

        // Round-robin: 1 then 3, then park on 0
        drv(0, 1'b0, T_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        drv(1, 1'b1, T_NONSEQ, 32'h1000, 1'b0, 1'b0, 32'h0);
        drv(3, 1'b1, T_NONSEQ, 32'h3000, 1'b0, 1'b0, 32'h0);
        cyc("rr_hop_m0", M_G | M_T, 4'b0001, 2'd0, T_IDLE, 0, 0, 0);
        cyc("rr_grant_m1", M_G | M_T | M_A, 4'b0010, 2'd1, T_NONSEQ, 32'h1000, 0, 0);
        drv(1, 1'b0, T_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc("rr_m1_idle", M_G, 4'b0010, 2'd1, 0, 0, 0, 0);
        cyc("rr_grant_m3", M_G | M_T | M_A, 4'b1000, 2'd3, T_NONSEQ, 32'h3000, 0, 0);
        drv(3, 1'b0, T_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc("rr_m3_idle", M_G, 4'b1000, 2'd3, 0, 0, 0, 0);
        cyc("park_m0", M_G | M_T, 4'b0001, 2'd0, T_IDLE, 0, 0, 0);

        // Write by master 2, last transfer overlaps master 1's address phase
        drv(2, 1'b1, T_NONSEQ, 32'h200, 1'b0, 1'b1, 32'h0);
        cyc("wr_hop_m2", M_G, 4'b0001, 2'd0, 0, 0, 0, 0);
        drv(2, 1'b0, T_NONSEQ, 32'h200, 1'b0, 1'b1, 32'h0);
        drv(1, 1'b1, T_NONSEQ, 32'h1100, 1'b0, 1'b0, 32'h1111_1111);
        cyc("wr_m2_addr", M_G | M_T | M_A, 4'b0100, 2'd2, T_NONSEQ, 32'h200, 0, 0);
        drv(2, 1'b0, T_IDLE, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        cyc("wr_overlap", M_G | M_A | M_W, 4'b0010, 2'd1, 0, 32'h1100, 32'hDEAD_BEEF, 0);

        // Locked sequence by master 1 while master 2 requests
        drv(1, 1'b1, T_NONSEQ, 32'h1200, 1'b1, 1'b0, 32'h1111_1111);
        drv(2, 1'b1, T_NONSEQ, 32'h2200, 1'b0, 1'b0, 32'h0);
        cyc("lock_start", M_G | M_A | M_W, 4'b0010, 2'd1, 0, 32'h1200, 32'h1111_1111, 0);
        drv(1, 1'b1, T_SEQ, 32'h1204, 1'b1, 1'b0, 32'h1111_1111);
        cyc("lock_seq1", M_G | M_T, 4'b0010, 2'd1, T_SEQ, 0, 0, 0);
        drv(1, 1'b1, T_SEQ, 32'h1208, 1'b1, 1'b0, 32'h1111_1111);
        cyc("lock_seq2", M_G, 4'b0010, 2'd1, 0, 0, 0, 0);
        drv(1, 1'b0, T_IDLE, 32'h0, 1'b0, 1'b0, 32'h1111_1111);
        cyc("lock_release", M_G, 4'b0010, 2'd1, 0, 0, 0, 0);
        cyc("lock_grant_m2", M_G | M_A, 4'b0100, 2'd2, 0, 32'h2200, 0, 0);

        // Three wait states then a two-cycle ERROR, master 1 waiting
        drv(2, 1'b1, T_NONSEQ, 32'h2204, 1'b0, 1'b0, 32'h0);
        drv(1, 1'b1, T_NONSEQ, 32'h1300, 1'b0, 1'b0, 32'h0);
        s_hreadyout = 1'b0;
        cyc("wait1", M_G | M_R, 4'b0100, 2'd2, 0, 0, 0, 4'b0000);
        cyc("wait2", M_G | M_R, 4'b0100, 2'd2, 0, 0, 0, 4'b0000);
        cyc("wait3", M_G | M_R, 4'b0100, 2'd2, 0, 0, 0, 4'b0000);
        drv(2, 1'b0, T_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        s_hresp = 1'b1;
        cyc("err1", M_G | M_R, 4'b0100, 2'd2, 0, 0, 0, 4'b0100);
        s_hreadyout = 1'b1;
        cyc("err2", M_G | M_R, 4'b0100, 2'd2, 0, 0, 0, 4'b0100);
        s_hresp = 1'b0;
        cyc("err_handover", M_G | M_A | M_R, 4'b0010, 2'd1, 0, 32'h1300, 0, 4'b0000);

        // Reset asserted mid-burst
        drv(1, 1'b1, T_SEQ, 32'h1304, 1'b0, 1'b0, 32'h0);
        cyc("burst_seq", M_G | M_T, 4'b0010, 2'd1, T_SEQ, 0, 0, 0);
        drv(1, 1'b1, T_SEQ, 32'h1308, 1'b0, 1'b0, 32'h0);
        hreset = 1'b1;
        cyc("reset_mid", M_G | M_T, 4'b0001, 2'd0, T_IDLE, 0, 0, 0);
        hreset = 1'b0;
        drv(1, 1'b0, T_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc("after_reset", M_G | M_T, 4'b0001, 2'd0, T_IDLE, 0, 0, 0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge hclk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: actual=%0d pending expected=0 pending", exp_q.size());
        end
        stim_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
